cache_read_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data caches' AXI read ports and drives the single AXI master read channel to the bus interface.
- Arbitrates AR requests with data-cache priority, registers the winning address, and tags it with an ARID.
- Routes each R beat back to its owner by RID.
- Allows at most one outstanding burst per cache; the two bursts may overlap.

---
 rtl/cache_read_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cache_read_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_read_arbiter.sv
// -----------------------------------------------------------------------------
// cache_read_arbiter
//   Merges the instruction-cache and data-cache AXI read address channels onto
//   one AXI master read port, then steers the returning R beats back to their
//   owner by RID. The data cache always wins arbitration. Each cache may have
//   at most one burst outstanding; the two bursts may overlap on the bus.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   i_ar*/i_r*                    instruction-cache AR request / R beat return
//   d_ar*/d_r*                    data-cache AR request / R beat return
//   arid, araddr, arlen, arsize,
//   arburst, arvalid, arready     master AR channel (arid/addr/len/valid are flops)
//   rid, rdata, rlast, rvalid,
//   rready                        master R channel
// -----------------------------------------------------------------------------
module cache_read_arbiter #(
    parameter int                    ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0]   I_ID     = ID_WIDTH'(0),
    parameter logic [ID_WIDTH-1:0]   D_ID     = ID_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    // icache side
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic                i_arvalid,
    output logic                i_arready,
    output logic [31:0]         i_rdata,
    output logic                i_rlast,
    output logic                i_rvalid,
    input  logic                i_rready,
    // dcache side
    input  logic [31:0]         d_araddr,
    input  logic [7:0]          d_arlen,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic [31:0]         d_rdata,
    output logic                d_rlast,
    output logic                d_rvalid,
    input  logic                d_rready,
    // master read channel
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    typedef enum logic {AR_IDLE, AR_ISSUE} state_t;

    state_t              state_q, state_d;
    logic                arvalid_q, arvalid_d;
    logic [ID_WIDTH-1:0] arid_q, arid_d;
    logic [31:0]         araddr_q, araddr_d;
    logic [7:0]          arlen_q, arlen_d;
    logic                out_i_q, out_i_d;   // icache burst outstanding
    logic                out_d_q, out_d_d;   // dcache burst outstanding

    logic i_elig, d_elig;
    logic route_i, route_d;

    assign i_elig = i_arvalid & ~out_i_q;
    assign d_elig = d_arvalid & ~out_d_q;

    // A beat is only routed when its owner actually has a burst in flight;
    // anything else (unknown ID, or stale beats after a reset) is drained.
    assign route_i = (rid == I_ID) & out_i_q;
    assign route_d = (rid == D_ID) & out_d_q;

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        out_i_d   = out_i_q;
        out_d_d   = out_d_q;
        i_arready = 1'b0;
        d_arready = 1'b0;

        case (state_q)
            AR_IDLE: begin
                // Held low during reset so nothing is granted while flops are cleared.
                d_arready = d_elig & ~rst;
                i_arready = i_elig & ~d_elig & ~rst;
                if (d_arready) begin
                    araddr_d  = d_araddr;
                    arlen_d   = d_arlen;
                    arid_d    = D_ID;
                    arvalid_d = 1'b1;
                    state_d   = AR_ISSUE;
                end else if (i_arready) begin
                    araddr_d  = i_araddr;
                    arlen_d   = i_arlen;
                    arid_d    = I_ID;
                    arvalid_d = 1'b1;
                    state_d   = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    state_d   = AR_IDLE;
                    if (arid_q == D_ID) out_d_d = 1'b1;
                    if (arid_q == I_ID) out_i_d = 1'b1;
                end
            end
            default: state_d = AR_IDLE;
        endcase

        // Set and clear never target the same flag in one cycle (a set needs
        // the flag low, a clear needs it high), so this ordering is safe.
        if (rvalid && rready && rlast) begin
            if (route_i) out_i_d = 1'b0;
            if (route_d) out_d_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= AR_IDLE;
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            out_i_q   <= 1'b0;
            out_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            out_i_q   <= out_i_d;
            out_d_q   <= out_d_d;
        end
    end

    assign arvalid = arvalid_q;
    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // Data and last are fanned out to both caches; only rvalid is steered.
    assign i_rdata  = rdata;
    assign i_rlast  = rlast;
    assign d_rdata  = rdata;
    assign d_rlast  = rlast;
    assign i_rvalid = rvalid & route_i;
    assign d_rvalid = rvalid & route_d;
    assign rready   = route_i ? i_rready : (route_d ? d_rready : 1'b1);

endmodule

// File: tb/tb_cache_read_arbiter.sv
module tb_cache_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata, araddr, rdata;
    logic [7:0]  i_arlen, d_arlen, arlen;
    logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic [3:0]  arid, rid;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cache_read_arbiter dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are changed at the falling edge; checks run 1 time unit later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_araddr = '0; i_arlen = '0; i_arvalid = 0; i_rready = 0;
        d_araddr = '0; d_arlen = '0; d_arvalid = 0; d_rready = 0;
        arready = 0; rid = '0; rdata = '0; rlast = 0; rvalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        #1;
        tick();
        rst = 0;
    endtask

    // Upstream request followed by an immediate master handshake.
    task automatic issue_req(input bit is_d, input logic [31:0] addr, input logic [7:0] len);
        if (is_d) begin d_arvalid = 1; d_araddr = addr; d_arlen = len; end
        else      begin i_arvalid = 1; i_araddr = addr; i_arlen = len; end
        #1;
        chk(is_d ? "d_arready grant" : "i_arready grant", is_d ? d_arready : i_arready, 1);
        tick();
        d_arvalid = 0; i_arvalid = 0; arready = 1;
        #1;
        chk("issue arvalid", arvalid, 1);
        chk("issue arid", arid, is_d ? 32'd1 : 32'd0);
        chk("issue araddr", araddr, addr);
        chk("issue arlen", arlen, len);
        tick();
        arready = 0;
        #1;
        chk("issue arvalid drop", arvalid, 0);
    endtask

    // One R beat held for one cycle, with expected routing.
    task automatic beat(input logic [3:0] id, input bit last, input logic [31:0] data,
                        input bit ir, input bit dr, input bit e_iv, input bit e_dv,
                        input bit e_rr, input bit e_dar);
        rid = id; rlast = last; rdata = data; rvalid = 1; i_rready = ir; d_rready = dr;
        #1;
        chk("beat i_rvalid", i_rvalid, e_iv);
        chk("beat d_rvalid", d_rvalid, e_dv);
        chk("beat rready", rready, e_rr);
        chk("beat i_rdata", i_rdata, data);
        chk("beat d_rdata", d_rdata, data);
        chk("beat i_rlast", i_rlast, last);
        chk("beat d_arready", d_arready, e_dar);
        tick();
        rvalid = 0; rlast = 0;
    endtask

    typedef struct {
        logic [3:0]  rid;
        logic        rvalid;
        logic        ir;
        logic        dr;
        logic [31:0] data;
        logic        e_iv;
        logic        e_dv;
        logic        e_rr;
    } rvec_t;

    rvec_t tbl[8];

    // Reference model: at most one AR waiting on the master port, plus a
    // per-cache "burst in flight" bit.
    typedef struct {
        logic [3:0]  id;
        logic [31:0] a;
        logic [7:0]  l;
    } req_t;

    initial begin
        req_t pq[$];
        bit   own[2];
        int   owner;
        bit   g_d, g_i, e_rr;

        tbl[0] = '{4'd0, 1'b1, 1'b1, 1'b0, 32'hA000_0001, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{4'd0, 1'b1, 1'b0, 1'b1, 32'hA000_0002, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'd1, 1'b1, 1'b0, 1'b1, 32'hB000_0003, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{4'd1, 1'b1, 1'b1, 1'b0, 32'hB000_0004, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{4'd5, 1'b1, 1'b0, 1'b0, 32'hC000_0005, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'd0, 1'b0, 1'b1, 1'b1, 32'hC000_0006, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{4'd1, 1'b0, 1'b0, 1'b0, 32'hC000_0007, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{4'd2, 1'b1, 1'b0, 1'b0, 32'hC000_0008, 1'b0, 1'b0, 1'b1};

        // ---------------- reset values ----------------
        clear_inputs();
        rst = 1;
        d_arvalid = 1; i_arvalid = 1;
        @(negedge clk);
        #1;
        chk("rst arvalid", arvalid, 0);
        chk("rst arid", arid, 0);
        chk("rst araddr", araddr, 0);
        chk("rst arlen", arlen, 0);
        chk("rst i_arready", i_arready, 0);
        chk("rst d_arready", d_arready, 0);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        do_reset();

        // ---------------- single icache burst, delayed arready ----------------
        i_arvalid = 1; i_araddr = 32'h1fc0_0000; i_arlen = 8'd7;
        #1;
        chk("A i_arready", i_arready, 1);
        chk("A d_arready", d_arready, 0);
        tick();
        i_arvalid = 0; i_araddr = 32'hdead_beef; i_arlen = 8'hff;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("A hold arvalid", arvalid, 1);
            chk("A hold arid", arid, 0);
            chk("A hold araddr", araddr, 32'h1fc0_0000);
            chk("A hold arlen", arlen, 7);
            chk("A issue i_arready", i_arready, 0);
            tick();
        end
        arready = 1;
        #1;
        tick();
        arready = 0;
        #1;
        chk("A arvalid after hs", arvalid, 0);
        for (int k = 0; k < 8; k++)
            beat(4'd0, k == 7, 32'h1000 + k, 1, 1, 1, 0, 1, 0);
        // out_i cleared: another rid 0 beat is discarded even with i_rready low
        beat(4'd0, 0, 32'h55, 0, 0, 0, 0, 1, 0);

        // ---------------- simultaneous requests ----------------
        do_reset();
        i_arvalid = 1; i_araddr = 32'h1fc0_0000; i_arlen = 8'd7;
        d_arvalid = 1; d_araddr = 32'h0000_1000; d_arlen = 8'd7;
        #1;
        chk("B d_arready", d_arready, 1);
        chk("B i_arready", i_arready, 0);
        tick();
        d_arvalid = 0; arready = 1;
        #1;
        chk("B d arvalid", arvalid, 1);
        chk("B d arid", arid, 1);
        chk("B d araddr", araddr, 32'h0000_1000);
        chk("B issue i_arready", i_arready, 0);
        tick();
        #1;
        chk("B gap arvalid", arvalid, 0);
        chk("B gap i_arready", i_arready, 1);
        tick();
        #1;
        chk("B i arvalid", arvalid, 1);
        chk("B i arid", arid, 0);
        chk("B i araddr", araddr, 32'h1fc0_0000);
        tick();
        i_arvalid = 0; arready = 0;
        #1;
        chk("B arvalid drop", arvalid, 0);

        // ---------------- routing table (both bursts in flight) ----------------
        foreach (tbl[n]) begin
            rid = tbl[n].rid; rvalid = tbl[n].rvalid; rlast = 0; rdata = tbl[n].data;
            i_rready = tbl[n].ir; d_rready = tbl[n].dr;
            #1;
            chk($sformatf("T%0d i_rvalid", n), i_rvalid, tbl[n].e_iv);
            chk($sformatf("T%0d d_rvalid", n), d_rvalid, tbl[n].e_dv);
            chk($sformatf("T%0d rready", n), rready, tbl[n].e_rr);
            chk($sformatf("T%0d d_rdata", n), d_rdata, tbl[n].data);
            tick();
        end
        rvalid = 0;

        // ---------------- overlap + dcache re-request while busy ----------------
        d_arvalid = 1; d_araddr = 32'h0000_2000; d_arlen = 8'd0;
        beat(4'd0, 0, 32'hA0, 1, 1, 1, 0, 1, 0);
        beat(4'd1, 0, 32'hB0, 1, 1, 0, 1, 1, 0);
        beat(4'd0, 0, 32'hA1, 1, 1, 1, 0, 1, 0);
        beat(4'd1, 1, 32'hB1, 1, 1, 0, 1, 1, 0);
        #1;
        chk("C d_arready after rlast", d_arready, 1);
        tick();
        d_arvalid = 0; arready = 1;
        #1;
        chk("C re arvalid", arvalid, 1);
        chk("C re arid", arid, 1);
        chk("C re araddr", araddr, 32'h0000_2000);
        chk("C re arlen", arlen, 0);
        tick();
        arready = 0;
        beat(4'd0, 1, 32'hA2, 1, 1, 1, 0, 1, 0);
        beat(4'd1, 1, 32'hB2, 1, 1, 0, 1, 1, 0);
        beat(4'd0, 0, 32'hA3, 0, 0, 0, 0, 1, 0);
        beat(4'd1, 0, 32'hB3, 0, 0, 0, 0, 1, 0);

        // ---------------- reset mid-burst ----------------
        do_reset();
        issue_req(0, 32'h1fc0_0040, 8'd7);
        beat(4'd0, 0, 32'hE0, 1, 0, 1, 0, 1, 0);
        beat(4'd0, 0, 32'hE1, 1, 0, 1, 0, 1, 0);
        d_arvalid = 1; d_araddr = 32'h3000; d_arlen = 0;
        beat(4'd0, 0, 32'hE2, 1, 0, 1, 0, 1, 1);
        d_arvalid = 0;
        rid = 0; rvalid = 1; rlast = 0; rdata = 32'hE3; i_rready = 0;
        #1;
        chk("R pre-rst arvalid", arvalid, 1);
        rst = 1;
        #1;
        chk("R rst arvalid", arvalid, 0);
        chk("R rst i_rvalid", i_rvalid, 0);
        chk("R rst rready", rready, 1);
        tick();
        rst = 0;
        for (int k = 0; k < 5; k++)
            beat(4'd0, k == 4, 32'hE3 + k, 0, 0, 0, 0, 1, 0);

        // ---------------- randomized against reference model ----------------
        do_reset();
        pq.delete();
        own[0] = 0; own[1] = 0;
        for (int c = 0; c < 400; c++) begin
            i_arvalid = ($urandom_range(0, 1) == 1);
            d_arvalid = ($urandom_range(0, 2) == 0);
            i_araddr = $urandom; i_arlen = 8'($urandom);
            d_araddr = $urandom; d_arlen = 8'($urandom);
            arready = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 4))
                0, 1:    rid = 4'd0;
                2, 3:    rid = 4'd1;
                default: rid = 4'd5;
            endcase
            rvalid = ($urandom_range(0, 1) == 1);
            rlast = ($urandom_range(0, 2) == 0);
            rdata = $urandom;
            i_rready = ($urandom_range(0, 3) != 0);
            d_rready = ($urandom_range(0, 3) != 0);
            #1;
            g_d = (pq.size() == 0) && d_arvalid && !own[1];
            g_i = (pq.size() == 0) && i_arvalid && !own[0] && !g_d;
            owner = (rid == 0 && own[0]) ? 0 : ((rid == 1 && own[1]) ? 1 : -1);
            e_rr = (owner == 0) ? i_rready : ((owner == 1) ? d_rready : 1'b1);
            chk("M d_arready", d_arready, g_d);
            chk("M i_arready", i_arready, g_i);
            chk("M arvalid", arvalid, pq.size() != 0);
            if (pq.size() != 0) begin
                chk("M arid", arid, pq[0].id);
                chk("M araddr", araddr, pq[0].a);
                chk("M arlen", arlen, pq[0].l);
            end
            chk("M i_rvalid", i_rvalid, rvalid && owner == 0);
            chk("M d_rvalid", d_rvalid, rvalid && owner == 1);
            chk("M rready", rready, e_rr);
            // advance the model across the coming edge
            if (rvalid && e_rr && rlast && owner >= 0) own[owner] = 0;
            if (pq.size() != 0) begin
                if (arready) begin
                    own[pq[0].id == 4'd1 ? 1 : 0] = 1;
                    void'(pq.pop_front());
                end
            end else if (g_d) begin
                pq.push_back('{4'd1, d_araddr, d_arlen});
            end else if (g_i) begin
                pq.push_back('{4'd0, i_araddr, i_arlen});
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
